hamming_encoder: RTL and testbench
==================================

# hamming_encoder

Streaming Hamming(12,8) encoder for the transmit path. It accepts bytes over a valid/ready handshake and computes the 12-bit single-error-correcting codeword. Codewords are buffered in a small FIFO and presented on a valid/ready output toward the serializer/line side. The codeword layout is the exact inverse of the team's Hamming(12,8) decoder. A one-shot error-injection hook and a sent-codeword counter support link testing.

## Interface
- DEPTH, 2: output FIFO entries; power of two, at least 2.
- CNT_W, 16: width of the sent-codeword counter.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  data byte d[7:0].
- in_valid  in  1  in_data is valid.
- in_ready  out  1  encoder can accept a byte.
- out_data  out  12  codeword hc[11:0] at the FIFO head.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- inj_mask  in  12  error pattern XORed into the next accepted codeword.
- inj_arm  in  1  1-cycle pulse that captures inj_mask and arms injection.
- inj_pending  out  1  injection is armed and not yet consumed.
- level  out  $clog2(DEPTH)+1  number of FIFO entries occupied.
- cw_count  out  CNT_W  count of codewords handed off downstream.

## Operation
- Codeword layout:
  - Data bits: hc[11:8]=d[7:4], hc[6:4]=d[3:1], hc[2]=d[0].
  - Parity bits:
    - hc[0]=d6^d4^d3^d1^d0
    - hc[1]=d6^d5^d3^d2^d0
    - hc[3]=d7^d3^d2^d1
    - hc[7]=d7^d6^d5^d4
  - With this layout, every syndrome of an unmodified codeword is zero at the decoder.
- Input accept occurs when in_valid && in_ready.
  - On accept, the codeword XOR effective mask is written at the FIFO tail.
  - The effective mask is the armed mask if inj_pending, else inj_mask if inj_arm is high this cycle, else 0.
- Output handshake occurs when out_valid && out_ready. The head entry is popped and cw_count increments, wrapping 2^CNT_W-1 -> 0.
- in_ready = (level != DEPTH). A push is refused while full even if a pop happens in the same cycle, so there is no combinational ready path.
- out_valid = (level != 0). out_data is driven from a register/RAM head; it is not combinational from in_data.
- Simultaneous push and pop with 0 < level < DEPTH: level is unchanged and pointers wrap modulo DEPTH.
- Injection control:
  - inj_arm without an accept in the same cycle captures inj_mask and sets inj_pending.
  - inj_arm while inj_pending already set overwrites the stored mask.
  - inj_arm in the same cycle as an accept applies inj_mask to that byte; inj_pending stays 0.
  - An accept with inj_pending set applies the stored mask and clears inj_pending.
  - An injected mask of 0 is legal and produces a clean codeword.
- Reset (any cycle, including mid-transfer) gives:
  - FIFO empty: level=0, out_valid=0, out_data=12'h000.
  - in_ready=1, inj_pending=0, stored mask=0, cw_count=0.
  - Contents in flight are discarded.

## Timing
- Latency: byte accepted in cycle N gives out_valid=1 with its codeword in cycle N+1 when the FIFO was empty.
- Throughput: one codeword per cycle while out_ready is held high.
- out_data and out_valid are held stable while out_valid && !out_ready.
- in_ready deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the first pop from full.
- inj_pending rises in the cycle after inj_arm and falls in the cycle after the consuming accept.
- cw_count and level update in the cycle after the handshake.
- First cycle after rst deasserts: in_ready=1, out_valid=0.

## Test plan
- Encoding vectors with out_ready=1, push 0x00, 0xFF, 0xA5, 0x01:
  - out_data must be 0x000, 0xF77, 0xA27, 0x007 respectively, each 1 cycle after its accept.
  - cw_count must read 4.
- Backpressure with out_ready=0, push 0x11, 0x22, 0x33:
  - With DEPTH=2, 0x33 is stalled by in_ready=0 and level=2.
  - Raise out_ready: the stream is exactly the codewords of 0x11, 0x22, 0x33 in order, with no duplicates or drops.
- Injection:
  - inj_arm with mask 0x004, idle 3 cycles, then push 0x00: out_data=0x004 and inj_pending falls.
  - A following push of 0x00 yields 0x000.
- Same-cycle arm and accept: push 0xFF together with inj_arm and mask 0x800. Required result is out_data=0x777 and inj_pending=0.
- Decoder loopback: all 256 bytes, each with 13 masks (0 plus the 12 single-bit masks), fed through the team decoder. Every decoded byte must equal the original.
- Reset mid-operation: FIFO full and inj_pending set, assert rst for 1 cycle. Required result is level=0, out_valid=0, in_ready=1, inj_pending=0, cw_count=0.

Source files
------------

// File: rtl/hamming_encoder_if.sv
// Byte-in / codeword-out handshake bundle for the Hamming(12,8) encoder, with the injection hook and status.
interface hamming_encoder_if #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
);
    logic [7:0]              in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [11:0]             out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [11:0]             inj_mask;
    logic                    inj_arm;
    logic                    inj_pending;
    logic [$clog2(DEPTH):0]  level;
    logic [CNT_W-1:0]        cw_count;

    modport master (
        output in_data, in_valid, out_ready, inj_mask, inj_arm,
        input  in_ready, out_data, out_valid, inj_pending, level, cw_count
    );

    modport slave (
        input  in_data, in_valid, out_ready, inj_mask, inj_arm,
        output in_ready, out_data, out_valid, inj_pending, level, cw_count
    );
endinterface

// File: rtl/hamming_encoder.sv
// Hamming(12,8) encoder into a DEPTH-entry FIFO; codeword visible 1 cycle after accept.
// in_ready depends only on registered occupancy, so a full FIFO refuses pushes even during a pop.
module hamming_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    hamming_encoder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [11:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pending_q;
    logic [11:0]      mask_q;

    logic             push;
    logic             pop;
    logic [7:0]       d;
    logic [11:0]      cw;
    logic [11:0]      eff_mask;

    assign bus.in_ready    = (level_q != LW'(DEPTH));
    assign bus.out_valid   = (level_q != '0);
    assign bus.out_data    = bus.out_valid ? mem[rd_ptr] : 12'h000;
    assign bus.level       = level_q;
    assign bus.cw_count    = cnt_q;
    assign bus.inj_pending = pending_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;
    assign d    = bus.in_data;

    // Parity bits sit at hc[0], hc[1], hc[3], hc[7] so the decoder syndrome is the error position.
    assign cw = {d[7:4],
                 d[7] ^ d[6] ^ d[5] ^ d[4],
                 d[3:1],
                 d[7] ^ d[3] ^ d[2] ^ d[1],
                 d[0],
                 d[6] ^ d[5] ^ d[3] ^ d[2] ^ d[0],
                 d[6] ^ d[4] ^ d[3] ^ d[1] ^ d[0]};

    always_comb begin
        eff_mask = 12'h000;
        if (pending_q)
            eff_mask = mask_q;
        else if (bus.inj_arm)
            eff_mask = bus.inj_mask;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= cw ^ eff_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            mask_q    <= 12'h000;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            // An accept always consumes the hook; an arm that coincides with it is applied directly.
            if (push) begin
                pending_q <= 1'b0;
                mask_q    <= 12'h000;
            end else if (bus.inj_arm) begin
                pending_q <= 1'b1;
                mask_q    <= bus.inj_mask;
            end
        end
    end
endmodule

// File: tb/tb_hamming_encoder.sv
// Randomised and directed bench for hamming_encoder against a textbook Hamming(12,8) model.
module tb_hamming_encoder;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;
    localparam int DPOS [8] = '{2, 4, 5, 6, 8, 9, 10, 11};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hamming_encoder_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    hamming_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [11:0]      exp_q [$];
    logic [7:0]       src_q [$];
    logic             m_pending = 1'b0;
    logic [11:0]      m_mask = '0;
    logic [CNT_W-1:0] m_count = '0;
    logic             lb_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Classic Hamming: position p = index+1; parity at p = 1,2,4,8 covers positions with that bit set.
    function automatic logic [11:0] enc(input logic [7:0] b);
        logic [11:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c[DPOS[i]] = b[i];
        for (int k = 0; k < 4; k++) begin
            int ones;
            ones = 0;
            for (int j = 0; j < 12; j++)
                if ((((j + 1) >> k) & 1) == 1 && c[j]) ones++;
            c[(1 << k) - 1] = (ones % 2 == 1);
        end
        return c;
    endfunction

    function automatic logic [7:0] extract(input logic [11:0] c);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = c[DPOS[i]];
        return b;
    endfunction

    // Nearest-codeword decode: try no flip, then every single flip.
    function automatic logic [7:0] dec(input logic [11:0] r);
        logic [11:0] t;
        for (int e = 0; e <= 12; e++) begin
            t = (e == 0) ? r : (r ^ (12'h001 << (e - 1)));
            if (enc(extract(t)) == t) return extract(t);
        end
        return extract(r);
    endfunction

    task automatic check_state();
        chk("out_valid",   32'(bus.out_valid),   32'(exp_q.size() != 0));
        chk("in_ready",    32'(bus.in_ready),    32'(exp_q.size() < DEPTH));
        chk("level",       32'(bus.level),       32'(exp_q.size()));
        chk("inj_pending", 32'(bus.inj_pending), 32'(m_pending));
        chk("cw_count",    32'(bus.cw_count),    32'(m_count));
        if (exp_q.size() != 0)
            chk("out_data", 32'(bus.out_data), 32'(exp_q[0]));
    endtask

    task automatic cycle(input logic v, input logic [7:0] dat, input logic arm,
                         input logic [11:0] msk, input logic ordy);
        logic push, pop;
        logic [11:0] eff, popped;
        logic [7:0]  psrc;
        bus.in_valid  = v;
        bus.in_data   = dat;
        bus.inj_arm   = arm;
        bus.inj_mask  = msk;
        bus.out_ready = ordy;
        push   = v && (exp_q.size() < DEPTH);
        pop    = ordy && (exp_q.size() != 0);
        popped = bus.out_data;
        psrc   = 8'h00;
        if (pop) begin
            void'(exp_q.pop_front());
            psrc = src_q.pop_front();
            m_count++;
            if (lb_en) chk("loopback", 32'(dec(popped)), 32'(psrc));
        end
        if (push) begin
            eff = m_pending ? m_mask : (arm ? msk : 12'h000);
            exp_q.push_back(enc(dat) ^ eff);
            src_q.push_back(dat);
            m_pending = 1'b0;
            m_mask    = '0;
        end else if (arm) begin
            m_pending = 1'b1;
            m_mask    = msk;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.inj_arm  = 1'b0;
        check_state();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b0, 12'h000, 1'b1);
    endtask

    task automatic model_reset();
        exp_q.delete();
        src_q.delete();
        m_pending = 1'b0;
        m_mask    = '0;
        m_count   = '0;
    endtask

    logic [7:0]  vec_in  [4] = '{8'h00, 8'hFF, 8'hA5, 8'h01};
    logic [11:0] vec_out [4] = '{12'h000, 12'hF77, 12'hA27, 12'h007};
    logic [7:0]  bp_in   [3] = '{8'h11, 8'h22, 8'h33};

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus.inj_arm = 1'b0; bus.inj_mask = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_state();
        chk("reset_out_data", 32'(bus.out_data), 32'h000);

        // Known encoding vectors, each visible one cycle after its accept.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, vec_in[i], 1'b0, 12'h000, 1'b1);
            chk("vector", 32'(bus.out_data), 32'(vec_out[i]));
        end
        cycle(1'b0, 8'h00, 1'b0, 12'h000, 1'b1);
        chk("vector_count", 32'(bus.cw_count), 32'd4);

        // Backpressure: third byte stalls until the sink opens.
        for (int i = 0; i < 3; i++) cycle(1'b1, bp_in[i], 1'b0, 12'h000, 1'b0);
        chk("bp_level", 32'(bus.level), 32'(DEPTH));
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        cycle(1'b1, 8'h33, 1'b0, 12'h000, 1'b1);
        cycle(1'b1, 8'h33, 1'b0, 12'h000, 1'b1);
        drain();
        chk("bp_count", 32'(bus.cw_count), 32'd7);

        // Deferred injection.
        cycle(1'b0, 8'h00, 1'b1, 12'h004, 1'b1);
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 12'h000, 1'b1);
        chk("inj_armed", 32'(bus.inj_pending), 32'd1);
        cycle(1'b1, 8'h00, 1'b0, 12'h000, 1'b1);
        chk("inj_applied", 32'(bus.out_data), 32'h004);
        chk("inj_cleared", 32'(bus.inj_pending), 32'd0);
        cycle(1'b1, 8'h00, 1'b0, 12'h000, 1'b1);
        chk("inj_oneshot", 32'(bus.out_data), 32'h000);
        drain();

        // Arm coinciding with accept.
        cycle(1'b1, 8'hFF, 1'b1, 12'h800, 1'b1);
        chk("inj_same_cycle", 32'(bus.out_data), 32'h777);
        chk("inj_same_pending", 32'(bus.inj_pending), 32'd0);
        drain();

        // Loopback through the nearest-codeword decoder.
        lb_en = 1'b1;
        for (int b = 0; b < 256; b++)
            for (int m = 0; m <= 12; m++)
                cycle(1'b1, 8'(b), 1'b1, (m == 0) ? 12'h000 : (12'h001 << (m - 1)), 1'b1);
        drain();
        lb_en = 1'b0;

        // Random traffic with random injection.
        for (int i = 0; i < 2000; i++) begin
            logic [11:0] msk;
            case ($urandom_range(0, 2))
                0:       msk = 12'h000;
                1:       msk = 12'h001 << $urandom_range(0, 11);
                default: msk = 12'($urandom);
            endcase
            cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 7) == 0),
                  msk, ($urandom_range(0, 2) != 0));
        end
        drain();

        // Reset while full with injection armed.
        cycle(1'b1, 8'h5A, 1'b0, 12'h000, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0, 12'h000, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 12'h0F0, 1'b0);
        chk("pre_rst_level", 32'(bus.level), 32'(DEPTH));
        chk("pre_rst_pending", 32'(bus.inj_pending), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check_state();
        chk("rst_out_data", 32'(bus.out_data), 32'h000);
        chk("rst_cw_count", 32'(bus.cw_count), 32'd0);
        cycle(1'b1, 8'hFF, 1'b0, 12'h000, 1'b1);
        chk("post_rst_clean", 32'(bus.out_data), 32'hF77);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
